// File: rtl/core_mem_resp.sv
// Core memory responder on the membus: accepts processor cycles, sequences address
// acknowledge and read restart, captures write data and runs the restore/write phase.
module core_mem_resp #(
  parameter logic [3:0]  SEL     = 4'b0000,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned ACK_DLY = 10,
  parameter int unsigned RD_DLY  = 20,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned WR_WIN  = 2,
  parameter int unsigned WR_DLY  = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        membus_mc_rq_cyc,
  input  logic        membus_mc_rd_rq,
  input  logic        membus_mc_wr_rq,
  input  logic        membus_mc_wr_rs,
  input  logic [14:0] membus_ma,
  input  logic [3:0]  membus_sel,
  input  logic        membus_fmc_select,
  input  logic [35:0] membus_mb_out,
  output logic        membus_mai_cmc_addr_ack,
  output logic        membus_mai_cmc_rd_rs,
  output logic [35:0] membus_mb_in,
  output logic        mem_busy
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] AckLast   = CntW'(ACK_DLY - 1);
  localparam logic [CntW-1:0] RdLast    = CntW'(RD_DLY - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0] PulseCnt  = CntW'(PULSE_W);
  localparam logic [CntW-1:0] WinCnt    = CntW'(WR_WIN);
  localparam logic [CntW-1:0] WrLast    = CntW'(WR_DLY - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StAccess, StAck, StRead, StRdrs, StWaitWr, StCapture, StWrite
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   hold_q;
  logic [CntW-1:0]   cap_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q, wr_q, armed_q, seen_q;
  logic [35:0]       wb_q, wb_d, rdata_q;
  logic [35:0]       mem_q [2**ADDR_W];

  logic accept, wr_only, ld_rd, clr_wb, see_wr, rdrs_end, do_write;
  logic unused_ma;

  // Address bits above ADDR_W are deliberately not decoded.
  assign unused_ma = ^membus_ma;

  assign accept = (state_q == StIdle) && membus_mc_rq_cyc && (membus_sel == SEL) &&
                  !membus_fmc_select && armed_q && (membus_mc_rd_rq || membus_mc_wr_rq);
  assign wr_only  = wr_q && !rd_q;
  assign ld_rd    = (state_q == StAck) && (cnt_q == PulseLast) && !wr_only;
  assign clr_wb   = (state_q != StWaitWr) && (state_d == StWaitWr);
  assign rdrs_end = (state_q == StRdrs) && (cnt_q == PulseLast);
  assign do_write = (state_q == StWrite) && (cnt_q == '0);
  // A write restart arriving during ACK of a write-only cycle is remembered.
  assign see_wr   = membus_mc_wr_rs && !seen_q &&
                    (((state_q == StAck) && wr_only) || (state_q == StWaitWr));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAccess;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (cnt_q == AckLast) begin
          state_d = StAck;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StAck: begin
        // Keep counting from the ack rise so READ can time RD_DLY from it.
        cnt_d = cnt_q + CntOne;
        if (cnt_q == PulseLast) state_d = wr_only ? StWaitWr : StRead;
      end
      StRead: begin
        if (cnt_q == RdLast) begin
          state_d = StRdrs;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRdrs: begin
        if (cnt_q == PulseLast) begin
          state_d = wr_q ? StWaitWr : StWrite;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitWr: begin
        if (seen_q || membus_mc_wr_rs) state_d = StCapture;
      end
      StCapture: begin
        if (cap_q <= CntOne) begin
          state_d = StWrite;
          cnt_d   = '0;
        end
      end
      StWrite: begin
        if (cnt_q == WrLast) state_d = StIdle;
        else                 cnt_d = cnt_q + CntOne;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_d = clr_wb ? '0 : wb_q;
    if (cap_q != '0) wb_d = wb_d | membus_mb_out;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
      cap_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      armed_q <= 1'b1;
      seen_q  <= 1'b0;
      wb_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= membus_ma[ADDR_W-1:0];
        rd_q   <= membus_mc_rd_rq;
        wr_q   <= membus_mc_wr_rq;
      end
      if (!membus_mc_rq_cyc) armed_q <= 1'b1;
      else if (accept)       armed_q <= 1'b0;
      if (accept)      seen_q <= 1'b0;
      else if (see_wr) seen_q <= 1'b1;
      if (see_wr)            cap_q <= WinCnt;
      else if (cap_q != '0)  cap_q <= cap_q - CntOne;
      if (rdrs_end)          hold_q <= PulseCnt;
      else if (hold_q != '0) hold_q <= hold_q - CntOne;
      if (ld_rd) begin
        wb_q    <= mem_q[addr_q];
        rdata_q <= mem_q[addr_q];
      end else begin
        wb_q <= wb_d;
      end
    end
  end

  // The array is only written during WRITE, so an abandoned cycle never loses data.
  always_ff @(posedge clk) begin
    if (reset_n && do_write) mem_q[addr_q] <= wb_q;
  end

  assign membus_mai_cmc_addr_ack = (state_q == StAck);
  assign membus_mai_cmc_rd_rs    = (state_q == StRdrs);
  assign membus_mb_in            = ((state_q == StRdrs) || (hold_q != '0)) ? rdata_q : '0;
  assign mem_busy                = (state_q != StIdle);

endmodule
